// File: rtl/flit_uart_serializer.sv
// flit_uart_serializer
//   Breaks one DATA_WIDTH-bit router flit into bytes, least-significant byte
//   first, and hands them one at a time to a UART byte transmitter. Each byte
//   is started with a single-cycle byte_send_en. The next byte is not started
//   until the UART returns byte_tx_done.
//
// Optional feature (compile-time macro FLIT_SER_SYNC_EN):
//   When defined, every flit is preceded by the sync byte 0xA5. The sync byte
//   goes through the same SEND/WAIT handshake as the payload bytes.
//
// Parameters
//   DATA_WIDTH    flit width in bits (32 or 64)
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   flit_valid    upstream presents a flit
//   flit_data     flit payload, captured on accept
//   flit_ready    block can accept a flit (IDLE)
//   byte_data     registered byte presented to the UART
//   byte_send_en  one-cycle start pulse for one UART byte
//   byte_tx_done  one-cycle pulse from the UART when a byte completes
//   busy          a flit is being serialized
//   flit_sent     one-cycle pulse after the last byte of a flit completes
module flit_uart_serializer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flit_valid,
  input  logic [DATA_WIDTH-1:0] flit_data,
  output logic                  flit_ready,
  output logic [7:0]            byte_data,
  output logic                  byte_send_en,
  input  logic                  byte_tx_done,
  output logic                  busy,
  output logic                  flit_sent
);

  localparam int NBYTES = DATA_WIDTH / 8;
`ifdef FLIT_SER_SYNC_EN
  // Slot 0 carries the sync byte; slot n+1 carries payload byte n.
  localparam int NSLOTS = NBYTES + 1;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
`else
  localparam int NSLOTS = NBYTES;
`endif
  localparam int IDX_W = $clog2(NBYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLOTS - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] flit_reg, flit_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic [7:0]            byte_reg, byte_next;

  // Payload byte that belongs to the slot after idx_reg.
  logic [IDX_W-1:0]      sel_idx;
  logic [7:0]            byte_pick [NBYTES];
  logic [7:0]            sel_byte;
  logic [7:0]            first_byte;

`ifdef FLIT_SER_SYNC_EN
  assign sel_idx    = idx_reg;
  assign first_byte = SYNC_BYTE;
`else
  assign sel_idx    = idx_reg + IDX_W'(1);
  assign first_byte = flit_data[7:0];
`endif

  // One-hot byte mux over the captured flit: each lane is zero unless selected.
  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi = gi + 1) begin : g_byte_lane
      assign byte_pick[gi] = (sel_idx == IDX_W'(gi)) ? flit_reg[8*gi +: 8] : 8'h00;
    end
  endgenerate

  always_comb begin
    sel_byte = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      sel_byte = sel_byte | byte_pick[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      flit_reg  <= '0;
      idx_reg   <= '0;
      byte_reg  <= 8'h00;
    end else begin
      state_reg <= state_next;
      flit_reg  <= flit_next;
      idx_reg   <= idx_next;
      byte_reg  <= byte_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    flit_next    = flit_reg;
    idx_next     = idx_reg;
    byte_next    = byte_reg;
    flit_ready   = 1'b0;
    busy         = 1'b1;
    byte_send_en = 1'b0;
    flit_sent    = 1'b0;
    case (state_reg)
      IDLE: begin
        flit_ready = 1'b1;
        busy       = 1'b0;
        if (flit_valid) begin
          flit_next  = flit_data;
          idx_next   = '0;
          // Load the first byte now so it is already stable in the SEND cycle.
          byte_next  = first_byte;
          state_next = SEND;
        end
      end
      SEND: begin
        byte_send_en = 1'b1;
        state_next   = WAIT;
      end
      WAIT: begin
        if (byte_tx_done) begin
          if (idx_reg == LAST_IDX) begin
            state_next = DONE;
          end else begin
            idx_next   = idx_reg + IDX_W'(1);
            byte_next  = sel_byte;
            state_next = SEND;
          end
        end
      end
      DONE: begin
        flit_sent  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign byte_data = byte_reg;

endmodule

// File: tb/tb_flit_uart_serializer.sv
// tb_flit_uart_serializer
//   Drives a 32-bit and a 64-bit serializer. sel64 routes the shared stimulus to
//   one instance and multiplexes that instance's outputs onto the ob_* signals.
//   The expected byte stream of each flit is computed from the flit value
//   (optional 0xA5 sync byte, then bytes LSB first). The UART is emulated with
//   fixed or random completion latency. Outputs are sampled on the falling edge.
module tb_flit_uart_serializer;

  logic        clk = 1'b0;
  logic        reset, flit_valid, byte_tx_done, sel64;
  logic [63:0] flit_data;

  logic        ready32, send32, busy32, sent32;
  logic [7:0]  byte32;
  logic        ready64, send64, busy64, sent64;
  logic [7:0]  byte64;

  logic        ob_ready, ob_send, ob_busy, ob_sent;
  logic [7:0]  ob_byte;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  flit_uart_serializer #(.DATA_WIDTH(32)) u32 (
    .clk(clk), .reset(reset),
    .flit_valid(flit_valid & ~sel64), .flit_data(flit_data[31:0]),
    .flit_ready(ready32), .byte_data(byte32), .byte_send_en(send32),
    .byte_tx_done(byte_tx_done & ~sel64), .busy(busy32), .flit_sent(sent32)
  );

  flit_uart_serializer #(.DATA_WIDTH(64)) u64 (
    .clk(clk), .reset(reset),
    .flit_valid(flit_valid & sel64), .flit_data(flit_data),
    .flit_ready(ready64), .byte_data(byte64), .byte_send_en(send64),
    .byte_tx_done(byte_tx_done & sel64), .busy(busy64), .flit_sent(sent64)
  );

  assign ob_ready = sel64 ? ready64 : ready32;
  assign ob_send  = sel64 ? send64  : send32;
  assign ob_busy  = sel64 ? busy64  : busy32;
  assign ob_sent  = sel64 ? sent64  : sent32;
  assign ob_byte  = sel64 ? byte64  : byte32;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, ob_ready, 1);
    chk({tag, "_busy"}, ob_busy, 0);
    chk({tag, "_send_en"}, ob_send, 0);
    chk({tag, "_flit_sent"}, ob_sent, 0);
  endtask

  // byte_tx_done while idle must not start anything.
  task automatic idle_done_pulses();
    for (int n = 0; n < 3; n++) begin
      byte_tx_done = 1'b1;
      @(negedge clk);
      byte_tx_done = 1'b0;
      chk_idle("idle_done");
    end
  endtask

  // Serialize one flit. Called on a falling edge.
  //   lat_fixed > 0 : UART done that many cycles after send_en, else random 1..6
  //   chain         : after accept keep flit_valid high presenting next_data
  //   spur_k        : byte slot whose SEND cycle also sees byte_tx_done
  //   abort_k       : byte slot whose WAIT is cut short by reset (-1 = none)
  task automatic do_flit(input logic [63:0] data, input int nb, input int lat_fixed,
                         input bit chain, input logic [63:0] next_data,
                         input int spur_k, input int abort_k);
    logic [7:0] exp_q[$];
    int waited;
    int lat;
`ifdef FLIT_SER_SYNC_EN
    exp_q.push_back(8'hA5);
`endif
    for (int i = 0; i < nb; i++) exp_q.push_back(8'((data >> (8 * i)) & 64'hFF));

    flit_valid = 1'b1;
    flit_data  = data;
    waited     = 0;
    while (!ob_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_ready", ob_ready, 1);
    @(negedge clk);
    if (chain) begin
      flit_data = next_data;
    end else begin
      flit_valid = 1'b0;
      flit_data  = {$urandom, $urandom};
    end

    for (int k = 0; k < exp_q.size(); k++) begin
      chk($sformatf("send_en[%0d]", k), ob_send, 1);
      chk($sformatf("byte[%0d]", k), ob_byte, exp_q[k]);
      chk($sformatf("busy_send[%0d]", k), {ob_busy, ob_ready}, 2'b10);
      lat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 6));
      for (int c = 0; c < lat; c++) begin
        byte_tx_done = (c == 0 && k == spur_k);
        @(negedge clk);
        byte_tx_done = 1'b0;
        chk($sformatf("wait_send_en[%0d]", k), ob_send, 0);
        chk($sformatf("hold_byte[%0d]", k), ob_byte, exp_q[k]);
        chk($sformatf("wait_flags[%0d]", k), {ob_busy, ob_sent}, 2'b10);
        if (k == abort_k && c == 0) begin
          reset = 1'b1;
          flit_valid = 1'b0;
          @(negedge clk);
          reset = 1'b0;
          chk("abort_byte", ob_byte, 8'h00);
          chk_idle("abort");
          byte_tx_done = 1'b1;
          @(negedge clk);
          byte_tx_done = 1'b0;
          for (int n = 0; n < 5; n++) begin
            chk("late_done_byte", ob_byte, 8'h00);
            chk_idle("late_done");
            @(negedge clk);
          end
          return;
        end
      end
      byte_tx_done = 1'b1;
      @(negedge clk);
      byte_tx_done = 1'b0;
    end

    chk("flit_sent_pulse", ob_sent, 1);
    chk("done_flags", {ob_busy, ob_ready, ob_send}, 3'b100);
    @(negedge clk);
    chk_idle("after_done");
  endtask

  initial begin
    reset        = 1'b1;
    flit_valid   = 1'b0;
    byte_tx_done = 1'b0;
    flit_data    = '0;
    sel64        = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst32_byte", ob_byte, 8'h00);
    chk_idle("rst32");
    sel64 = 1'b1;
    #1;
    chk("rst64_byte", ob_byte, 8'h00);
    chk_idle("rst64");
    sel64 = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk_idle("post_rst");

    idle_done_pulses();

    // Fixed 20-cycle UART, second flit held valid throughout the first.
    do_flit(64'h11223344, 4, 20, 1'b1, 64'hAABBCCDD, -1, -1);
    // Chained flit, spurious done during the SEND cycle of slot 1.
    do_flit(64'hAABBCCDD, 4, 0, 1'b0, 64'h0, 1, -1);
    idle_done_pulses();

    // Reset during WAIT of slot 2 abandons the flit.
    do_flit({$urandom, $urandom}, 4, 0, 1'b0, 64'h0, -1, 2);
    // The next flit must start cleanly from slot 0.
    do_flit(64'hCAFEF00D, 4, 0, 1'b0, 64'h0, -1, -1);
    for (int r = 0; r < 4; r++) begin
      do_flit({$urandom, $urandom}, 4, 0, ($urandom_range(0, 1) == 1), 64'h0, -1, -1);
      flit_valid = 1'b0;
    end

    sel64 = 1'b1;
    #1;
    chk_idle("sel64_idle");
    @(negedge clk);
    do_flit(64'h0102030405060708, 8, 0, 1'b0, 64'h0, -1, -1);
    for (int r = 0; r < 2; r++) begin
      do_flit({$urandom, $urandom}, 8, 0, 1'b0, 64'h0, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
